rr_encoder8to3: RTL and testbench



---
 rtl/rr_encoder8to3.sv | 143 ++++++++++++++
 tb/tb_rr_encoder8to3.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder8to3.sv
// rr_encoder8to3
// ---------------------------------------------------------------------------
// Sequential 8-to-3 request encoder / arbiter. Several request lines compete
// for one resource, such as write-back sources contending for the
// register-file write port. The block picks one winner. It presents the
// winner as a registered 3-bit index plus a one-hot grant. It holds that
// result under a valid/ack handshake until the consumer takes it.
//
// Configuration macro:
//   RR_ENCODER_ROUND_ROBIN_EN
//     defined   : round-robin. After an ack, the search starts just past the
//                 last winner.
//     undefined : fixed priority. Index 0 is highest and index 7 is lowest.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high reset
//   en     in   1  enable; when 0, no new grant is issued
//   req    in   8  request vector; bit i requests index i
//   ack    in   1  consumer accepts the current index (only used while valid)
//   valid  out  1  addr/grant hold a decided winner
//   addr   out  3  encoded winner index
//   grant  out  8  one-hot of addr while valid, zero otherwise
//   busy   out  1  high while a grant is held (same as valid)
// ---------------------------------------------------------------------------
module rr_encoder8to3 #(
    parameter int NREQ = 8,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            ack,
    output logic            valid,
    output logic [AW-1:0]   addr,
    output logic [NREQ-1:0] grant,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [AW-1:0]   ptr;

    logic            found;
    logic [AW-1:0]   win;
    logic [AW-1:0]   idx;

`ifdef RR_ENCODER_ROUND_ROBIN_EN
    logic [AW-1:0]   ptr_d;
`else
    // Fixed priority: the search always starts at index 0.
    assign ptr = '0;
`endif

    // Circular search that starts at ptr. The first asserted request wins.
    // Index arithmetic is AW bits wide, so the wrap from 7 to 0 is free.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + AW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // State register. It also holds the outputs, so they stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
        end
    end

`ifdef RR_ENCODER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_d;
        end
    end
`endif

    // Next-state logic. While a grant is held it ignores req and en.
    // The grant only leaves on ack. Once acked, the next selection
    // happens in the following IDLE cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        grant_d = grant_q;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        ptr_d   = ptr;
`endif
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = GRANT;
                    addr_d  = win;
                    grant_d = NREQ'(1) << win;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d = IDLE;
                    grant_d = '0;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
                    // The last winner gets the lowest priority next time.
                    ptr_d   = addr_q + AW'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output decode. It reads registers only.
    always_comb begin
        valid = (state_q == GRANT);
        busy  = (state_q == GRANT);
        addr  = addr_q;
        grant = grant_q;
    end

endmodule

// File: tb/tb_rr_encoder8to3.sv
// tb_rr_encoder8to3
// Self-checking bench for rr_encoder8to3. A behavioural model tracks the
// expected handshake state and the priority pointer. The model searches
// with plain modulo arithmetic. Each scenario task drives stimulus and
// compares the DUT against the model and/or against hand-derived constants.
module tb_rr_encoder8to3;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic       valid;
    logic [2:0] addr;
    logic [7:0] grant;
    logic       busy;

    int errors;
    int checks;

    // Reference model state
    logic       m_valid;
    logic [2:0] m_addr;
    logic [7:0] m_grant;
    int         m_ptr;

    rr_encoder8to3 dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .ack   (ack),
        .valid (valid),
        .addr  (addr),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // Advance the model with the current inputs, then clock the DUT and
    // settle past the edge.
    task automatic tick();
        int w;
        if (reset) begin
            m_valid = 1'b0;
            m_addr  = 3'd0;
            m_grant = 8'h00;
            m_ptr   = 0;
        end else if (!m_valid) begin
            w = pick(m_ptr, req);
            if (en && w >= 0) begin
                m_valid = 1'b1;
                m_addr  = 3'(w);
                m_grant = 8'(1 << w);
            end
        end else if (ack) begin
            m_valid = 1'b0;
            m_grant = 8'h00;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
            m_ptr   = (int'(m_addr) + 1) % 8;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; req = 8'h00; ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 8'hFF; en = 1'b1; ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({valid, busy, addr, grant} !== 13'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got valid=%b busy=%b addr=%0d grant=%h, expected all zero",
                         i, valid, busy, addr, grant);
            end
        end
        reset = 1'b0; ack = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 3'd0 || grant !== 8'h01) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got valid=%b addr=%0d grant=%h, expected 1/0/01", valid, addr, grant);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'b0010_0000; en = 1'b1; ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || addr !== 3'd5 || grant !== 8'h20) begin
                errors++;
                $display("[TB] FAIL single_hold cycle %0d: got valid=%b busy=%b addr=%0d grant=%h, expected 1/1/5/20",
                         i, valid, busy, addr, grant);
            end
        end
        ack = 1'b1; req = 8'h00;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || grant !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack: got valid=%b busy=%b grant=%h, expected 0/0/00", valid, busy, grant);
        end
    endtask

    task automatic test_enable();
        do_reset();
        req = 8'hFF; en = 1'b0; ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL enable_gated cycle %0d: got valid=%b, expected 0", i, valid);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL enable_release: got valid=%b addr=%0d, expected 1/0", valid, addr);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_arbitration();
        int exp_addr;
        do_reset();
        req = 8'hFF; en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ack = m_valid;
            tick();
`ifdef RR_ENCODER_ROUND_ROBIN_EN
            exp_addr = (i / 2) % 8;
`else
            exp_addr = 0;
`endif
            checks++;
            if (valid !== (i % 2 == 0)) begin
                errors++;
                $display("[TB] FAIL arb_valid cycle %0d: got valid=%b, expected %0d", i, valid, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                checks++;
                if (addr !== 3'(exp_addr) || grant !== 8'(1 << exp_addr)) begin
                    errors++;
                    $display("[TB] FAIL arb_addr cycle %0d: got addr=%0d grant=%h, expected %0d", i, addr, grant, exp_addr);
                end
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 8'h08; en = 1'b1; ack = 1'b0;
        tick();
        req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            en = (i != 1);
            tick();
            checks++;
            if (valid !== 1'b1 || addr !== 3'd3 || grant !== 8'h08) begin
                errors++;
                $display("[TB] FAIL withdraw_hold cycle %0d: got valid=%b addr=%0d grant=%h, expected 1/3/08",
                         i, valid, addr, grant);
            end
        end
        en = 1'b1; ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack = (i == 1);
            tick();
            checks++;
            if (valid !== 1'b0 || grant !== 8'h00 || addr !== 3'd3) begin
                errors++;
                $display("[TB] FAIL withdraw_idle cycle %0d: got valid=%b addr=%0d grant=%h, expected 0/3/00",
                         i, valid, addr, grant);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'h02; en = 1'b1; ack = 1'b0;
        tick();
        ack = 1'b1; req = 8'h40;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ack_cycle: got valid=%b, expected 0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 3'd6) begin
            errors++;
            $display("[TB] FAIL b2b_next_grant: got valid=%b addr=%0d, expected 1/6", valid, addr);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h10; en = 1'b1; ack = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0; req = 8'h40;
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 3'd6) begin
            errors++;
            $display("[TB] FAIL midreset_setup: got valid=%b addr=%0d, expected 1/6", valid, addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (valid !== 1'b0 || grant !== 8'h00 || addr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midreset_drop: got valid=%b addr=%0d grant=%h, expected 0/0/00", valid, addr, grant);
        end
        req = 8'h90;
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 3'd4 || grant !== 8'h10) begin
            errors++;
            $display("[TB] FAIL midreset_ptr: got valid=%b addr=%0d grant=%h, expected 1/4/10", valid, addr, grant);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            en    = ($urandom_range(0, 3) != 0);
            ack   = ($urandom_range(0, 2) == 0);
            req   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            tick();
            checks++;
            if ({valid, busy, addr, grant} !== {m_valid, m_valid, m_addr, m_grant}) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got valid=%b busy=%b addr=%0d grant=%h, expected valid=%b addr=%0d grant=%h",
                         i, valid, busy, addr, grant, m_valid, m_addr, m_grant);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        m_valid = 1'b0; m_addr = 3'd0; m_grant = 8'h00; m_ptr = 0;
        reset = 1'b1; en = 1'b0; req = 8'h00; ack = 1'b0;
        test_reset();
        test_single();
        test_enable();
        test_arbitration();
        test_withdraw();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
